// File: rtl/norm_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its buffers/normalizer.
// frame_sum exists only when NORM_SEQ_CHECKSUM_EN is defined.
interface norm_frame_sequencer_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        norm_pixel_in;
    logic              norm_valid_in;
    logic [15:0]       norm_pixel_out;
    logic              norm_valid_out;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
`ifdef NORM_SEQ_CHECKSUM_EN
    logic [23:0]       frame_sum;
`endif

    modport master (
        input  start, rd_data, norm_pixel_out, norm_valid_out, wr_ready,
        output busy, done, rd_en, rd_addr, norm_pixel_in, norm_valid_in,
               wr_en, wr_addr, wr_data
`ifdef NORM_SEQ_CHECKSUM_EN
        , output frame_sum
`endif
    );

    modport slave (
        output start, rd_data, norm_pixel_out, norm_valid_out, wr_ready,
        input  busy, done, rd_en, rd_addr, norm_pixel_in, norm_valid_in,
               wr_en, wr_addr, wr_data
`ifdef NORM_SEQ_CHECKSUM_EN
        , input frame_sum
`endif
    );
endinterface

// File: rtl/norm_frame_sequencer.sv
// Sequences one frame through the 8-bit -> Q8.8 normalizer; reads are credit-throttled
// so the skid FIFO never overflows. Define NORM_SEQ_CHECKSUM_EN for the frame_sum output.
module norm_frame_sequencer #(
    parameter int unsigned IMG_W        = 28,
    parameter int unsigned IMG_H        = 28,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned NORM_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    norm_frame_sequencer_if.master bus
);
    localparam int unsigned N      = IMG_W * IMG_H;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned CRED_W = PTR_W + 2;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned DAT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_d;
    logic               busy_q, done_q, busy_d, done_d;
    logic [CNT_W-1:0]   rd_cnt, wr_cnt, wr_cnt_d;
    logic               rd_en_q;
    logic [PIX_W-1:0]   pix_hold;
    logic [FCNT_W-1:0]  in_flight;
    logic [DAT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]  fifo_cnt;
    logic [CRED_W-1:0]  credit;
    logic               start_ok, rd_fire, push, pop, fifo_full, fifo_nempty;
    logic [DAT_W-1:0]   head;

    // Every read is counted exactly once: issued (rd_en_q), in the normalizer, or queued.
    always_comb begin
        credit      = CRED_W'(in_flight) + CRED_W'(fifo_cnt) + CRED_W'(rd_en_q);
        start_ok    = (state == S_IDLE) && bus.start;
        rd_fire     = (state == S_RUN) && (rd_cnt < CNT_W'(N))
                      && (credit < CRED_W'(FIFO_DEPTH));
        push        = bus.norm_valid_out && (state != S_IDLE);
        fifo_nempty = (fifo_cnt != '0);
        fifo_full   = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
        pop         = fifo_nempty && bus.wr_ready;
        wr_cnt_d    = wr_cnt + CNT_W'(pop);
        head        = fifo_mem[rd_ptr];
    end

    always_comb begin
        state_d = state;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (rd_cnt == CNT_W'(N)) state_d = S_DRAIN;
            S_DRAIN: if (wr_cnt_d == CNT_W'(N)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_en_q   <= 1'b0;
            pix_hold  <= '0;
            in_flight <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            rd_en_q <= rd_fire;
            if (rd_en_q) pix_hold <= bus.rd_data;

            if (start_ok) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_fire) rd_cnt <= rd_cnt + CNT_W'(1);
                wr_cnt <= wr_cnt_d;
            end

            case ({rd_en_q, push})
                2'b10:   in_flight <= in_flight + FCNT_W'(1);
                2'b01:   in_flight <= in_flight - FCNT_W'(1);
                default: in_flight <= in_flight;
            endcase

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: wr_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.norm_pixel_out;
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rd_en         = rd_fire;
    assign bus.rd_addr       = rd_cnt[ADDR_W-1:0];
    assign bus.norm_valid_in = rd_en_q;
    assign bus.norm_pixel_in = rd_en_q ? bus.rd_data : pix_hold;
    assign bus.wr_en         = fifo_nempty;
    assign bus.wr_addr       = wr_cnt[ADDR_W-1:0];
    assign bus.wr_data       = fifo_nempty ? head : '0;

`ifdef NORM_SEQ_CHECKSUM_EN
    localparam int unsigned SUM_W = 24;
    logic [SUM_W-1:0] frame_sum;

    always_ff @(posedge clk) begin
        if (!rst)          frame_sum <= '0;
        else if (start_ok) frame_sum <= '0;
        else if (pop)      frame_sum <= frame_sum + SUM_W'(head);
    end

    assign bus.frame_sum = frame_sum;
`endif

    assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full))
        else $fatal(1, "norm_frame_sequencer: push into full skid fifo");

    assert property (@(posedge clk) disable iff (!rst)
                     in_flight <= FCNT_W'(NORM_LATENCY + 1))
        else $fatal(1, "norm_frame_sequencer: normalizer occupancy above latency bound");
endmodule

// File: tb/tb_norm_frame_sequencer.sv
// Randomized self-checking bench for norm_frame_sequencer on a 4x4 frame.
// Buffer and normalizer are behavioural; expected pixels come from out = in*256/255.
module tb_norm_frame_sequencer;
    localparam int N            = 16;
    localparam int ADDR_W       = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int NORM_LATENCY = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    norm_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    norm_frame_sequencer #(
        .IMG_W(4), .IMG_H(4), .ADDR_W(ADDR_W),
        .NORM_LATENCY(NORM_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]  img  [N];
    logic [15:0] seen [N];
    bit          pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, wr_idx = 0, n_rd = 0, n_wr = 0, n_done = 0;
    int first_rd = -1, first_wr = -1, last_wr = -100;
    bit prev_stall = 1'b0;
    logic [23:0] exp_sum = '0;

    // Synchronous input frame buffer: data one cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= img[bus.rd_addr];
    end

    // Registered normalizer, latency 1.
    always @(posedge clk) begin
        bus.norm_valid_out <= bus.norm_valid_in;
        if (bus.norm_valid_in)
            bus.norm_pixel_out <= 16'((32'(bus.norm_pixel_in) * 32'd256) / 32'd255);
    end

    function automatic logic [15:0] exp_px(input int k);
        if (k < 0 || k >= N) return 16'hDEAD;
        return 16'((int'(img[k]) * 256) / 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        wr_idx = 0; n_rd = 0; n_wr = 0; n_done = 0;
        first_rd = -1; first_wr = -1; last_wr = -100;
        prev_stall = 1'b0; exp_sum = '0;
    endtask

    // One clock: observe at negedge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst) begin
            if (bus.rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
            end
            check("credit_bound", 32'((n_rd - n_wr) <= FIFO_DEPTH), 32'd1);
            if (prev_stall) check("stall_hold_wr_en", 32'(bus.wr_en), 32'd1);
            if (bus.wr_en) begin
                if (first_wr < 0) first_wr = cyc;
                check("wr_addr", 32'(bus.wr_addr), 32'(wr_idx));
                check("wr_data", 32'(bus.wr_data), 32'(exp_px(wr_idx)));
                if (bus.wr_ready) begin
                    if (wr_idx < N) seen[wr_idx] = bus.wr_data;
                    exp_sum = exp_sum + 24'(exp_px(wr_idx));
                    wr_idx++;
                    n_wr++;
                    last_wr = cyc;
                end
            end
            prev_stall = bus.wr_en && !bus.wr_ready;
            if (bus.done) begin
                n_done++;
                check("done_after_last_wr", 32'(cyc), 32'(last_wr + 1));
                check("busy_low_at_done", 32'(bus.busy), 32'd0);
`ifdef NORM_SEQ_CHECKSUM_EN
                check("frame_sum_at_done", 32'(bus.frame_sum), 32'(exp_sum));
`endif
            end
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    // mode: 0 ready, 1 pattern 1,0,0,1, 2 stall 20 cycles, 3 random ready, 4 start while busy
    task automatic run_frame(input int mode, input int budget);
        int cnt;
        clear_counts();
        bus.wr_ready = (mode != 2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        cnt = 0;
        while (n_done == 0 && cnt < budget) begin
            case (mode)
                1:       bus.wr_ready = pat[cnt % 4];
                2:       bus.wr_ready = (cnt >= 20);
                3:       bus.wr_ready = 1'($urandom_range(0, 1));
                default: bus.wr_ready = 1'b1;
            endcase
            bus.start = (mode == 4 && cnt == 4);
            if (mode == 2 && cnt == 20) begin
                check("stall_reads", 32'(n_rd), 32'(FIFO_DEPTH));
                check("stall_fifo_occupancy", 32'(n_rd - n_wr), 32'(FIFO_DEPTH));
                check("stall_wr_en", 32'(bus.wr_en), 32'd1);
            end
            tick();
            cnt++;
        end
        bus.start = 1'b0;
        bus.wr_ready = 1'b1;
        check("done_seen", 32'(n_done), 32'd1);
        check("write_count", 32'(n_wr), 32'(N));
        check("read_count", 32'(n_rd), 32'(N));
        repeat (5) tick();
        check("single_done", 32'(n_done), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("no_extra_reads", 32'(n_rd), 32'(N));
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_busy"},    32'(bus.busy), 32'd0);
        check({pfx, "_done"},    32'(bus.done), 32'd0);
        check({pfx, "_rd_en"},   32'(bus.rd_en), 32'd0);
        check({pfx, "_nvi"},     32'(bus.norm_valid_in), 32'd0);
        check({pfx, "_wr_en"},   32'(bus.wr_en), 32'd0);
        check({pfx, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        check({pfx, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({pfx, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({pfx, "_npi"},     32'(bus.norm_pixel_in), 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.wr_ready = 1'b0;
        for (int i = 0; i < N; i++) img[i] = '0;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b1;
        tick();

        // T1: ramp frame, full throughput
        for (int i = 0; i < N; i++) img[i] = 8'(16 * i);
        run_frame(0, 300);
        check("t1_latency", 32'(first_wr - first_rd), 32'(NORM_LATENCY + 2));
        check("t1_consecutive", 32'(last_wr - first_wr), 32'(N - 1));
        check("t1_addr4", 32'(seen[4]), 32'h0040);
        check("t1_addr15", 32'(seen[15]), 32'h00F0);

        // T2: toggling backpressure
        fill_random();
        run_frame(1, 300);

        // T3: long stall at frame start
        fill_random();
        run_frame(2, 300);

        // T4: start while busy
        fill_random();
        run_frame(4, 300);

        // T5: reset after six writes, then a fresh frame with new data
        fill_random();
        clear_counts();
        bus.wr_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cnt = 0;
        while (n_wr < 6 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("t5_partial_writes", 32'(n_wr), 32'd6);
        rst = 1'b0;
        tick();
        check_reset_state("t5_reset");
        tick();
        rst = 1'b1;
        check("t5_no_done", 32'(n_done), 32'd0);
        fill_random();
        run_frame(0, 300);

        // Random backpressure frames
        for (int f = 0; f < 2; f++) begin
            fill_random();
            run_frame(3, 400);
        end

`ifdef NORM_SEQ_CHECKSUM_EN
        // T6: saturated pixels give 1.0 in Q8.8 and a known checksum
        for (int i = 0; i < N; i++) img[i] = 8'hFF;
        run_frame(0, 300);
        check("t6_px0", 32'(seen[0]), 32'h0100);
        check("t6_frame_sum", 32'(bus.frame_sum), 32'h001000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/norm_frame_sequencer.md
Name: norm_frame_sequencer

Overview:
- Frame-level controller that sequences the 8-bit→Q8.8 pixel normalizer over one image.
- Reads raw pixels from the input frame buffer and drives the normalizer's pixel/valid inputs.
- Captures the normalizer's output in a small skid FIFO and writes normalized pixels to the output buffer.
- Credit scheme: the normalizer cannot stall, so reads are throttled to guarantee the FIFO never overflows under write backpressure.

Parameters:
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- NORM_LATENCY, 1, normalizer cycles from valid_in to valid_out (>=1)
- FIFO_DEPTH, 4, skid FIFO entries (power of 2, >= NORM_LATENCY+2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle frame start request
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when last pixel written
- rd_en  out  1  input buffer read strobe
- rd_addr  out  ADDR_W  input buffer address
- rd_data  in  8  raw pixel, valid the cycle after rd_en
- norm_pixel_in  out  8  to normalizer
- norm_valid_in  out  1  to normalizer
- norm_pixel_out  in  16  from normalizer, Q8.8
- norm_valid_out  in  1  from normalizer
- wr_en  out  1  output write request
- wr_ready  in  1  output buffer accepts when high
- wr_addr  out  ADDR_W  output address
- wr_data  out  16  normalized pixel

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; busy, done, rd_en, norm_valid_in, wr_en = 0; rd_addr, wr_addr, wr_data, norm_pixel_in = 0; in_flight and FIFO count = 0.
- Let N = IMG_W*IMG_H.
- States:
  - IDLE: start=1 → RUN; clear counters; busy=1 next cycle.
  - RUN: issue reads; → DRAIN once read count = N.
  - DRAIN: no reads; → DONE when write count = N.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- start while busy is ignored. start in the DONE cycle is ignored; a new start is accepted from IDLE on the following cycle.
- Read issue:
  - rd_en=1 iff state=RUN, read count < N, and in_flight + fifo_count + rd_en_q < FIFO_DEPTH (rd_en_q = rd_en registered 1 cycle).
  - rd_addr increments by 1 after each rd_en, 0..N-1, with no wrap within a frame.
- Normalizer drive:
  - norm_valid_in = rd_en delayed 1 cycle; norm_pixel_in = rd_data in that cycle.
  - norm_pixel_in holds its last value when norm_valid_in=0.
- in_flight:
  - +1 on norm_valid_in, −1 on norm_valid_out; simultaneous events leave it unchanged.
  - Never exceeds NORM_LATENCY+1.
- FIFO:
  - norm_valid_out pushes norm_pixel_out.
  - wr_en = FIFO non-empty (first-word-fall-through); wr_data = FIFO head.
  - A transfer (wr_en & wr_ready) pops the head and increments wr_addr.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees no push when full. The RTL carries an assertion: push when full is a fatal error.
- Ordering: wr_addr k carries the normalized rd_addr k; in-order, no gaps.
- Backpressure: wr_ready=0 holds wr_en, wr_data, wr_addr stable.
- Throughput: with wr_ready=1 continuously, sustains 1 pixel/cycle.
- Latency: first wr_en appears NORM_LATENCY+2 cycles after the first rd_en. done pulses the cycle after the N-th write transfer.
- norm_valid_out in IDLE is ignored and not pushed.
- Reset mid-frame: immediate return to IDLE with all state cleared; no done pulse. The partial output frame is undefined.

Optional Feature:
- Macro NORM_SEQ_CHECKSUM_EN.
- With it defined:
  - Extra output port frame_sum, 24 bits: running sum of wr_data over accepted transfers, cleared on accepted start and on reset.
  - frame_sum holds its final value from the done cycle until the next accepted start.
- Without it: port and logic absent; all other behaviour identical.

Test Plan:
- Bench setup: IMG_W=4, IMG_H=4, NORM_LATENCY=1, FIFO_DEPTH=4. Behavioural normalizer model: out = (in*256)/255, registered.
- T1 basic frame: input buffer pixel k = 16*k, wr_ready=1, pulse start → 16 writes on consecutive cycles, addresses 0..15. Addr 4 (pixel 64) = 0x0040; addr 15 (pixel 240) = 0x00F0. done one pulse; busy low after.
- T2 backpressure: wr_ready toggles 1,0,0,1,… → wr_data/wr_addr stable while stalled, no write lost or duplicated, in_flight+fifo never > 4, all 16 values correct.
- T3 full stall: wr_ready=0 for 20 cycles after start → rd_en stops after 4 reads, FIFO holds 4. wr_ready=1 → frame completes correctly.
- T4 start while busy: second start at cycle 5 of a frame → ignored, exactly 16 writes, one done.
- T5 reset mid-frame: rst=0 after 6 writes, then start → new frame restarts at rd_addr 0/wr_addr 0, 16 correct writes, no stale data.
- T6 (NORM_SEQ_CHECKSUM_EN): all pixels 255 → every wr_data=0x0100, frame_sum=0x001000 at done.
